ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
- Sequences the PS/2 receiver FIFO: pops one scan byte at a time via the nextdata_n handshake and decodes Set-2 make/break/extended sequences.
- Tracks the currently held key, emits press/release/repeat pulses and keeps a wrapping press counter.
- Sits between ps2_keyboard and the display/ASCII path; it replaces ad-hoc F0 counting in the top level.

Parameters:
- CNT_W, 8, width of press_count.
- TIMEOUT_CYCLES, 1000000, prefix-expiry limit in clock cycles (used only with PS2_PREFIX_TIMEOUT_EN).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  receiver FIFO head byte, valid while rx_ready=1
- rx_ready  in  1  receiver FIFO non-empty
- rx_overflow  in  1  receiver FIFO overflow indication
- rx_nextdata_n  out  1  active-low pop strobe to receiver
- key_code  out  8  scan code of held or last-held key
- key_ext  out  1  key_code carried the E0 prefix
- key_held  out  1  a key is currently held
- key_press  out  1  one-cycle pulse, new key pressed
- key_release  out  1  one-cycle pulse, held key released
- key_repeat  out  1  one-cycle pulse, typematic repeat of held key
- press_count  out  CNT_W  number of new presses, wraps
- ovf_sticky  out  1  receiver overflow seen since reset

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: rx_nextdata_n=1, key_code=0, key_ext=0, key_held=0, all pulses 0, press_count=0, ovf_sticky=0, prefixes cleared, FSM in S_IDLE.
- Reset mid-handshake aborts the pop: rx_nextdata_n returns to 1 on the next cycle and the byte is not decoded.
- FSM S_IDLE: if rx_ready=1, latch rx_data into byte_r and go to S_ACK. Otherwise stay.
- FSM S_ACK: rx_nextdata_n=0 for exactly this cycle. Decode byte_r; results register at the end of the cycle. Go to S_GAP.
- FSM S_GAP: rx_nextdata_n=1. Pulses are visible in this cycle only. Go to S_IDLE.
- Throughput is 1 byte per 3 cycles. Pulse latency is 2 cycles after the accept edge.
- All outputs are registered.
- Decode rules (prefix flags ext_p and brk_p):
  - 0xE0: set ext_p.
  - 0xF0: set brk_p. Order of E0/F0 is irrelevant.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF: ignore and clear both prefixes.
  - Other byte with brk_p=1: if key_held and {ext_p,byte} equals {key_ext,key_code}, then key_held<=0 and key_release pulses. Otherwise no change and no pulse. Clear both prefixes.
  - Other byte with brk_p=0, and key_held with a matching {ext_p,byte}: key_repeat pulses, count unchanged.
  - Other byte with brk_p=0, otherwise: key_code<=byte, key_ext<=ext_p, key_held<=1, key_press pulses, press_count++. Last key wins. Clear both prefixes.
- key_code/key_ext hold their last value after release.
- press_count wraps from 2^CNT_W-1 to 0.
- rx_overflow=1 in any cycle: ovf_sticky<=1, cleared only by reset.
  - Prefixes are cleared; the held key is unaffected.
  - If coincident with S_ACK, decode uses the pre-clear prefix values, then the clear wins.
- rx_ready dropping during S_ACK/S_GAP is ignored; the latched byte is still decoded.

Optional Feature:
- Macro: PS2_PREFIX_TIMEOUT_EN.
- Defined: a counter resets on every byte accepted in S_IDLE and runs while ext_p or brk_p is set. When it reaches TIMEOUT_CYCLES-1, both prefixes clear and the counter stops.
- Not defined: prefixes persist until the next code byte. No counter logic is synthesized.

Decomposition:
- Package ps2_ctrl_pkg:
  - FSM state enum (S_IDLE/S_ACK/S_GAP).
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Non-key code constants.
  - Default CNT_W.
- One sub-module, ps2_prefix_timeout: the expiry counter, instantiated only under the macro.
- All other logic stays in ps2_key_ctrl.

Test Plan:
- Bytes 1C,F0,1C -> key_press with key_code=1C, key_held=1, press_count=1; then key_release, key_held=0, key_code stays 1C. rx_nextdata_n low exactly 3 single cycles.
- Bytes 1B,1B,1B,F0,1B -> 1 key_press, 2 key_repeat, 1 key_release, press_count=1.
- Bytes E0,75 then E0,F0,75 -> key_ext=1 with key_code=75, then released. F0,75 (no E0) while E0 75 is held -> no release.
- Bytes 1C,1B,F0,1C -> key_code=1B, key_held=1, press_count=2, no release pulse. Then bytes 1C ×255 alternating with 1B so every byte is a new press -> press_count wraps to 1.
- Byte F0, rx_overflow pulsed 1 cycle, byte 2D -> ovf_sticky=1, 2D treated as press (count+1). Reset asserted while in S_ACK -> all outputs at reset values, rx_nextdata_n=1 the next cycle.
- With PS2_PREFIX_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte F0, idle 20 cycles, byte 1C -> 1C is a press. With the macro undefined, the same stimulus gives no press and no state change.

Source files
------------

// File: rtl/ps2_ctrl_pkg.sv
// Shared types and constants for the PS/2 key controller: FSM states,
// Set-2 prefix bytes and the keyboard status/response codes that carry no key.
package ps2_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_GAP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam int unsigned PS2_CNT_W_DEF = 8;

  function automatic logic is_non_key(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
           (b == PS2_ACK)  || (b == PS2_RESEND) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_prefix_timeout.sv
// Expiry counter for pending E0/F0 prefixes; built only when
// PS2_PREFIX_TIMEOUT_EN is defined.
module ps2_prefix_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Parks at LIMIT after expiry; only a newly accepted byte re-arms it.
  always_ff @(posedge clock) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (run && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = run && (cnt == LIMIT) && !restart;

endmodule

// File: rtl/ps2_key_ctrl.sv
// Pops PS/2 scan bytes from the receiver FIFO and decodes Set-2 make/break/E0
// sequences into held-key state and press/release/repeat pulses.
// Define PS2_PREFIX_TIMEOUT_EN to expire stale prefixes after TIMEOUT_CYCLES.
module ps2_key_ctrl
  import ps2_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W          = PS2_CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_ready,
  input  logic             rx_overflow,
  output logic             rx_nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_held,
  output logic             key_press,
  output logic             key_release,
  output logic             key_repeat,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_sticky
);

  ps2_state_e state;
  logic [7:0] byte_r;
  logic       ext_p;
  logic       brk_p;
  logic       pfx_expire;
  logic       match;

`ifdef PS2_PREFIX_TIMEOUT_EN
  ps2_prefix_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_prefix_timeout (
    .clock  (clock),
    .reset  (reset),
    .restart(state == S_IDLE && rx_ready),
    .run    (ext_p || brk_p),
    .expire (pfx_expire)
  );
`else
  assign pfx_expire = 1'b0;
`endif

  assign match = key_held && ({ext_p, byte_r} == {key_ext, key_code});

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      byte_r        <= '0;
      ext_p         <= 1'b0;
      brk_p         <= 1'b0;
      rx_nextdata_n <= 1'b1;
      key_code      <= '0;
      key_ext       <= 1'b0;
      key_held      <= 1'b0;
      key_press     <= 1'b0;
      key_release   <= 1'b0;
      key_repeat    <= 1'b0;
      press_count   <= '0;
      ovf_sticky    <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      if (rx_overflow) ovf_sticky <= 1'b1;
      if (pfx_expire) begin
        ext_p <= 1'b0;
        brk_p <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (rx_ready) begin
            byte_r        <= rx_data;
            rx_nextdata_n <= 1'b0;
            state         <= S_ACK;
          end
        end
        S_ACK: begin
          rx_nextdata_n <= 1'b1;
          state         <= S_GAP;
          if (byte_r == PS2_EXT) begin
            ext_p <= 1'b1;
          end else if (byte_r == PS2_BRK) begin
            brk_p <= 1'b1;
          end else begin
            ext_p <= 1'b0;
            brk_p <= 1'b0;
            if (!is_non_key(byte_r)) begin
              if (brk_p) begin
                if (match) begin
                  key_held    <= 1'b0;
                  key_release <= 1'b1;
                end
              end else if (match) begin
                key_repeat <= 1'b1;
              end else begin
                key_code    <= byte_r;
                key_ext     <= ext_p;
                key_held    <= 1'b1;
                key_press   <= 1'b1;
                press_count <= press_count + CNT_W'(1);
              end
            end
          end
        end
        S_GAP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Overflow discards partial sequences; decode above already used the old prefixes.
      if (rx_overflow) begin
        ext_p <= 1'b0;
        brk_p <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl against a behavioural key model.
// Honours PS2_PREFIX_TIMEOUT_EN for the prefix-expiry scenario.
module tb_ps2_key_ctrl;

  localparam int CNT_W      = 8;
  localparam int TB_TIMEOUT = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready = 1'b0;
  logic             rx_overflow = 1'b0;
  logic             rx_nextdata_n;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_held;
  logic             key_press;
  logic             key_release;
  logic             key_repeat;
  logic [CNT_W-1:0] press_count;
  logic             ovf_sticky;

  ps2_key_ctrl #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_overflow  (rx_overflow),
    .rx_nextdata_n(rx_nextdata_n),
    .key_code     (key_code),
    .key_ext      (key_ext),
    .key_held     (key_held),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_repeat   (key_repeat),
    .press_count  (press_count),
    .ovf_sticky   (ovf_sticky)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic       nd;
    logic [7:0] code;
    logic       ext;
    logic       held;
    logic       press;
    logic       rel;
    logic       rep;
    logic [7:0] cnt;
    logic       ovf;
  } obs_t;

  localparam obs_t RESET_OBS = '{nd: 1'b1, default: '0};

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the held key as a (ext, code) pair plus pending prefixes.
  logic [7:0] m_code;
  logic       m_ext, m_held, m_ext_p, m_brk_p, m_ovf;
  int         m_cnt;

  function automatic void model_reset();
    m_code = 8'h00; m_ext = 0; m_held = 0; m_ext_p = 0; m_brk_p = 0; m_ovf = 0; m_cnt = 0;
  endfunction

  // Returns 0 none, 1 press, 2 release, 3 repeat.
  function automatic int model_byte(input logic [7:0] b);
    int  ev;
    bit  same;
    ev = 0;
    same = m_held && (m_ext_p == m_ext) && (b == m_code);
    if (b == 8'hE0) m_ext_p = 1;
    else if (b == 8'hF0) m_brk_p = 1;
    else begin
      if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
        if (m_brk_p) begin
          if (same) begin m_held = 0; ev = 2; end
        end else if (same) ev = 3;
        else begin
          m_code = b; m_ext = m_ext_p; m_held = 1; ev = 1;
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
      end
      m_ext_p = 0; m_brk_p = 0;
    end
    return ev;
  endfunction

  function automatic void model_idle(input int ncycles);
`ifdef PS2_PREFIX_TIMEOUT_EN
    if (ncycles >= TB_TIMEOUT + 2) begin m_ext_p = 0; m_brk_p = 0; end
`else
    if (ncycles < 0) m_ext_p = 0;
`endif
  endfunction

  function automatic obs_t exp_obs(input int ev);
    obs_t e;
    e.nd = 1'b1; e.code = m_code; e.ext = m_ext; e.held = m_held;
    e.press = (ev == 1); e.rel = (ev == 2); e.rep = (ev == 3);
    e.cnt = 8'(m_cnt); e.ovf = m_ovf;
    return e;
  endfunction

  function automatic obs_t sample();
    return '{rx_nextdata_n, key_code, key_ext, key_held, key_press, key_release,
             key_repeat, press_count, ovf_sticky};
  endfunction

  // Offers one byte like a FIFO head, returns outputs sampled in the gap cycle.
  task automatic send_byte(input logic [7:0] b, output obs_t o, output int lows);
    bit got;
    got = 0; lows = 0;
    rx_data = b; rx_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (rx_nextdata_n === 1'b0) got = 1;
    end
    n_assert++;
    if (!got) begin
      n_fail++;
      $display("FAIL ack_wait: rx_nextdata_n never went low for byte %h", b);
      rx_ready = 1'b0; o = '0;
      return;
    end
    lows = 1;
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    @(negedge clock);
    o = sample();
    if (o.nd === 1'b0) lows++;
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_ready = 1'b0; rx_overflow = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    o = sample();
    n_assert++;
    if (o !== RESET_OBS) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", o, RESET_OBS);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_press_release();
    logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
    obs_t o, e;
    int   lows, total_lows;
    total_lows = 0;
    do_reset();
    foreach (seq[i]) begin
      e = exp_obs(model_byte(seq[i]));
      send_byte(seq[i], o, lows);
      total_lows += lows;
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL press_release[%0d]: got %h expected %h", i, o, e); end
    end
    n_assert++;
    if (total_lows != 3) begin n_fail++; $display("FAIL nextdata_low_cycles: got %0d expected 3", total_lows); end
    n_assert++;
    if ({key_code, key_held, press_count} !== {8'h1C, 1'b0, 8'd1}) begin
      n_fail++; $display("FAIL release_keeps_code: got %h/%b/%0d expected 1c/0/1", key_code, key_held, press_count);
    end
  endtask

  task automatic test_repeat();
    logic [7:0] seq [5] = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};
    obs_t o, e;
    int   lows, np, nr, nq;
    np = 0; nr = 0; nq = 0;
    do_reset();
    foreach (seq[i]) begin
      e = exp_obs(model_byte(seq[i]));
      send_byte(seq[i], o, lows);
      np += int'(o.press); nq += int'(o.rep); nr += int'(o.rel);
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL repeat[%0d]: got %h expected %h", i, o, e); end
    end
    n_assert++;
    if ({np, nq, nr} != {32'd1, 32'd2, 32'd1} || press_count !== 8'd1) begin
      n_fail++; $display("FAIL repeat_counts: got press=%0d rep=%0d rel=%0d cnt=%0d expected 1/2/1/1", np, nq, nr, press_count);
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [9] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h75, 8'hF0, 8'h75};
    obs_t o, e;
    int   lows;
    do_reset();
    foreach (seq[i]) begin
      e = exp_obs(model_byte(seq[i]));
      send_byte(seq[i], o, lows);
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL extended[%0d]: got %h expected %h", i, o, e); end
    end
    n_assert++;
    if ({key_ext, key_code, key_held} !== {1'b1, 8'h75, 1'b1}) begin
      n_fail++; $display("FAIL plain_break_vs_ext: got ext=%b code=%h held=%b expected 1/75/1", key_ext, key_code, key_held);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4] = '{8'h1C, 8'h1B, 8'hF0, 8'h1C};
    obs_t o, e;
    int   lows, nrel;
    nrel = 0;
    do_reset();
    foreach (seq[i]) begin
      e = exp_obs(model_byte(seq[i]));
      send_byte(seq[i], o, lows);
      nrel += int'(o.rel);
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL last_key_wins[%0d]: got %h expected %h", i, o, e); end
    end
    n_assert++;
    if ({key_code, key_held, press_count} !== {8'h1B, 1'b1, 8'd2} || nrel != 0) begin
      n_fail++; $display("FAIL last_key_state: got %h/%b/%0d rel=%0d expected 1b/1/2/0", key_code, key_held, press_count, nrel);
    end
    for (int i = 0; i < 255; i++) begin
      logic [7:0] b;
      b = (i % 2 == 0) ? 8'h1C : 8'h1B;
      e = exp_obs(model_byte(b));
      send_byte(b, o, lows);
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_step[%0d]: got %h expected %h", i, o, e); end
    end
    n_assert++;
    if (press_count !== 8'd1) begin n_fail++; $display("FAIL press_count_wrap: got %0d expected 1", press_count); end
  endtask

  task automatic test_overflow();
    obs_t o, e;
    int   lows;
    do_reset();
    e = exp_obs(model_byte(8'hF0));
    send_byte(8'hF0, o, lows);
    @(negedge clock) rx_overflow = 1'b1;
    @(negedge clock) rx_overflow = 1'b0;
    m_ovf = 1; m_ext_p = 0; m_brk_p = 0;
    e = exp_obs(model_byte(8'h2D));
    send_byte(8'h2D, o, lows);
    n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL overflow_press: got %h expected %h", o, e); end
    n_assert++;
    if ({ovf_sticky, key_press, press_count} !== {1'b1, 1'b1, 8'd1}) begin
      n_fail++; $display("FAIL overflow_sticky: got ovf=%b press=%b cnt=%0d expected 1/1/1", ovf_sticky, key_press, press_count);
    end
  endtask

  task automatic test_reset_mid_ack();
    obs_t o;
    int   lows;
    bit   got;
    do_reset();
    send_byte(8'h1C, o, lows);
    got = 0;
    rx_data = 8'h2D; rx_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (rx_nextdata_n === 1'b0) got = 1;
    end
    reset = 1'b1; rx_ready = 1'b0;
    @(negedge clock);
    o = sample();
    n_assert++;
    if (!got || o !== RESET_OBS) begin
      n_fail++; $display("FAIL reset_mid_ack: ack_seen=%b got %h expected %h", got, o, RESET_OBS);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'hE0, 8'h5A, 8'hF0, 8'h1C};
    obs_t o, e;
    int   prev;
    bit   got;
    do_reset();
    prev = -1;
    rx_ready = 1'b1; rx_data = seq[0];
    foreach (seq[i]) begin
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clock);
        if (rx_nextdata_n === 1'b0) got = 1;
      end
      e = exp_obs(model_byte(seq[i]));
      if (i > 0) begin
        n_assert++;
        if (!got || cyc - prev != 3) begin
          n_fail++; $display("FAIL throughput[%0d]: got spacing %0d expected 3", i, cyc - prev);
        end
      end
      prev = cyc;
      if (i < 5) rx_data = seq[i+1];
      else rx_ready = 1'b0;
      @(negedge clock);
      o = sample();
      n_assert++;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, o, e); end
    end
    rx_ready = 1'b0;
  endtask

  task automatic test_prefix_timeout();
    obs_t o, e;
    int   lows;
    logic exp_press;
`ifdef PS2_PREFIX_TIMEOUT_EN
    exp_press = 1'b1;
`else
    exp_press = 1'b0;
`endif
    do_reset();
    e = exp_obs(model_byte(8'hF0));
    send_byte(8'hF0, o, lows);
    repeat (20) @(negedge clock);
    model_idle(20);
    e = exp_obs(model_byte(8'h1C));
    send_byte(8'h1C, o, lows);
    n_assert++;
    if (o !== e) begin n_fail++; $display("FAIL prefix_timeout: got %h expected %h", o, e); end
    n_assert++;
    if ({o.press, o.held, o.cnt} !== {exp_press, exp_press, 7'd0, exp_press}) begin
      n_fail++; $display("FAIL prefix_timeout_press: got press=%b held=%b cnt=%0d expected %b", o.press, o.held, o.cnt, exp_press);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'h1C, 8'h1B, 8'h2D, 8'h75, 8'hE0, 8'hF0, 8'hAA, 8'h00};
    obs_t o, e;
    int   lows;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      b = pool[$urandom_range(0, 7)];
      e = exp_obs(model_byte(b));
      send_byte(b, o, lows);
      n_assert++;
      if (o !== e || lows != 1) begin
        n_fail++; $display("FAIL random[%0d] byte %h: got %h lows=%0d expected %h lows=1", i, b, o, lows, e);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_press_release();
    test_repeat();
    test_extended();
    test_wrap();
    test_overflow();
    test_reset_mid_ack();
    test_back_to_back();
    test_prefix_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
